// File: rtl/bsg_clk_watch_monitor_if.sv
// Signal bundle between a clock-watch monitor and whatever configures/observes it.
// master: the controller (bench or SoC glue); slave: the monitor itself.
interface bsg_clk_watch_monitor_if #(
    parameter int unsigned count_width_p     = 16,
    parameter int unsigned err_count_width_p = 8
);
    logic                         en_i;
    logic                         ref_toggle_i;
    logic [count_width_p-1:0]     expected_i;
    logic [count_width_p-1:0]     tolerance_i;
    logic [count_width_p-1:0]     count_o;
    logic                         count_v_o;
    logic [count_width_p-1:0]     min_o;
    logic [count_width_p-1:0]     max_o;
    logic                         error_o;
    logic [err_count_width_p-1:0] error_count_o;
    logic                         ref_lost_o;
    logic                         locked_o;

    modport master (
        output en_i, ref_toggle_i, expected_i, tolerance_i,
        input  count_o, count_v_o, min_o, max_o, error_o, error_count_o, ref_lost_o, locked_o
    );

    modport slave (
        input  en_i, ref_toggle_i, expected_i, tolerance_i,
        output count_o, count_v_o, min_o, max_o, error_o, error_count_o, ref_lost_o, locked_o
    );
endinterface

// File: rtl/bsg_clk_watch_monitor.sv
// Clock-frequency monitor clocked by the clock under test. Counts clk_lo cycles between
// transitions of an asynchronous reference toggle, discards settle windows after arming,
// tracks min/max, flags out-of-band windows and loss of the reference.
module bsg_clk_watch_monitor #(
    parameter int unsigned count_width_p     = 16,
    parameter int unsigned settle_windows_p  = 1,
    parameter int unsigned err_count_width_p = 8,
    parameter int unsigned sync_stages_p     = 2
) (
    input  logic                  clk_lo,
    input  logic                  tag_reset,
    bsg_clk_watch_monitor_if.slave mon_if
);
    localparam int unsigned settle_width_lp =
        (settle_windows_p > 1) ? $clog2(settle_windows_p) : 1;
    localparam int unsigned settle_last_int_lp =
        (settle_windows_p > 0) ? settle_windows_p - 1 : 0;
    localparam logic [settle_width_lp-1:0]   settle_last_lp  = settle_width_lp'(settle_last_int_lp);
    localparam logic [count_width_p-1:0]     cnt_max_lp      = '1;
    localparam logic [count_width_p-1:0]     cnt_near_max_lp = cnt_max_lp - count_width_p'(1);
    localparam logic [err_count_width_p-1:0] err_max_lp      = '1;

    typedef enum logic [1:0] {StIdle, StArm, StSettle, StMeasure} state_e;

    state_e                         state_q, state_d;
    logic [sync_stages_p-1:0]       sync_q, sync_d;
    logic                           hist_q, hist_d;
    logic [count_width_p-1:0]       cnt_q, cnt_d;
    logic [settle_width_lp-1:0]     settle_q, settle_d;
    logic [count_width_p-1:0]       count_q, count_d;
    logic                           count_v_q, count_v_d;
    logic [count_width_p-1:0]       min_q, min_d;
    logic [count_width_p-1:0]       max_q, max_d;
    logic                           stat_v_q, stat_v_d;
    logic                           error_q, error_d;
    logic [err_count_width_p-1:0]   err_cnt_q, err_cnt_d;
    logic                           ref_lost_q, ref_lost_d;

    logic                           ref_edge;
    logic [count_width_p-1:0]       window;
    logic [count_width_p:0]         win_x, exp_x, dev;
    logic                           out_of_band;
    logic [err_count_width_p-1:0]   err_cnt_inc;

    // Reference synchronizer and edge detect (either direction ends a window).
    always_comb begin
        sync_d   = {sync_q[sync_stages_p-2:0], mon_if.ref_toggle_i};
        hist_d   = sync_q[sync_stages_p-1];
        ref_edge = sync_q[sync_stages_p-1] ^ hist_q;
    end

    // Window length, deviation from expected (one extra bit so nothing wraps), error bump.
    always_comb begin
        window      = (cnt_q == cnt_max_lp) ? cnt_max_lp : cnt_q + count_width_p'(1);
        win_x       = {1'b0, window};
        exp_x       = {1'b0, mon_if.expected_i};
        dev         = (win_x >= exp_x) ? (win_x - exp_x) : (exp_x - win_x);
        out_of_band = dev > {1'b0, mon_if.tolerance_i};
        err_cnt_inc = (err_cnt_q == err_max_lp) ? err_max_lp : err_cnt_q + err_count_width_p'(1);
    end

    // FSM next state and statistics update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = ref_edge ? '0 : window;
        settle_d   = settle_q;
        count_d    = count_q;
        count_v_d  = 1'b0;
        min_d      = min_q;
        max_d      = max_q;
        stat_v_d   = stat_v_q;
        error_d    = error_q;
        err_cnt_d  = err_cnt_q;
        ref_lost_d = ref_lost_q;

        if (!mon_if.en_i || state_q == StIdle) begin
            // Disable wins over a coincident edge; everything returns to zero.
            state_d    = mon_if.en_i ? StArm : StIdle;
            cnt_d      = '0;
            settle_d   = '0;
            count_d    = '0;
            min_d      = '0;
            max_d      = '0;
            stat_v_d   = 1'b0;
            error_d    = 1'b0;
            err_cnt_d  = '0;
            ref_lost_d = 1'b0;
        end else begin
            case (state_q)
                StArm: begin
                    if (ref_edge) begin
                        settle_d = '0;
                        state_d  = (settle_windows_p == 0) ? StMeasure : StSettle;
                    end
                end
                StSettle: begin
                    if (ref_edge) begin
                        if (settle_q == settle_last_lp) begin
                            state_d = StMeasure;
                        end else begin
                            settle_d = settle_q + settle_width_lp'(1);
                        end
                    end
                end
                StMeasure: begin
                    if (ref_edge) begin
                        count_d    = window;
                        count_v_d  = 1'b1;
                        ref_lost_d = 1'b0;
                        stat_v_d   = 1'b1;
                        if (!stat_v_q || window < min_q) min_d = window;
                        if (!stat_v_q || window > max_q) max_d = window;
                        if (out_of_band) begin
                            error_d   = 1'b1;
                            err_cnt_d = err_cnt_inc;
                        end
                    end else if (cnt_q == cnt_near_max_lp) begin
                        // Counter is about to saturate: one loss event per silent stretch.
                        ref_lost_d = 1'b1;
                        error_d    = 1'b1;
                        err_cnt_d  = err_cnt_inc;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Synchronizer flops.
    always_ff @(posedge clk_lo or negedge tag_reset) begin
        if (!tag_reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    // State, counters and statistics registers.
    always_ff @(posedge clk_lo or negedge tag_reset) begin
        if (!tag_reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            settle_q   <= '0;
            count_q    <= '0;
            count_v_q  <= 1'b0;
            min_q      <= '0;
            max_q      <= '0;
            stat_v_q   <= 1'b0;
            error_q    <= 1'b0;
            err_cnt_q  <= '0;
            ref_lost_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            settle_q   <= settle_d;
            count_q    <= count_d;
            count_v_q  <= count_v_d;
            min_q      <= min_d;
            max_q      <= max_d;
            stat_v_q   <= stat_v_d;
            error_q    <= error_d;
            err_cnt_q  <= err_cnt_d;
            ref_lost_q <= ref_lost_d;
        end
    end

    assign mon_if.count_o       = count_q;
    assign mon_if.count_v_o     = count_v_q;
    assign mon_if.min_o         = min_q;
    assign mon_if.max_o         = max_q;
    assign mon_if.error_o       = error_q;
    assign mon_if.error_count_o = err_cnt_q;
    assign mon_if.ref_lost_o    = ref_lost_q;
    assign mon_if.locked_o      = (state_q == StMeasure);
endmodule

// File: doc/bsg_clk_watch_monitor.md
Name: bsg_clk_watch_monitor

Overview:
- Synthesizable, parametrised clock-frequency monitor clocked by the clock under test (clk_lo).
- Counts clk_lo cycles between edges of an asynchronous reference toggle.
- Discards a configurable number of settle windows so start-up glitches are ignored.
- Tracks min/max window counts, flags windows outside expected±tolerance, and detects loss of the reference.
- Sits beside the clock-generator pearl; replaces the nonsynth watcher for on-chip and bench use.

Parameters:
- count_width_p, 16: width of window cycle counter and of expected/tolerance/min/max.
- settle_windows_p, 1: complete windows discarded after arming before measurement (0 allowed).
- err_count_width_p, 8: width of saturating error counter.
- sync_stages_p, 2: synchronizer depth for ref_toggle_i (>=2).

Ports:
- clk_lo  input  1  clock under test; all state on its rising edge.
- tag_reset  input  1  asynchronous, active-low reset.
- en_i  input  1  enable; 0 forces IDLE and clears statistics.
- ref_toggle_i  input  1  asynchronous reference; each transition (either direction) ends a window.
- expected_i  input  count_width_p  expected clk_lo cycles per window.
- tolerance_i  input  count_width_p  allowed absolute deviation.
- count_o  output  count_width_p  last measured window count.
- count_v_o  output  1  one-cycle pulse when count_o updates.
- min_o  output  count_width_p  minimum measured count since entering MEASURE.
- max_o  output  count_width_p  maximum measured count since entering MEASURE.
- error_o  output  1  sticky: any out-of-tolerance window or ref loss.
- error_count_o  output  err_count_width_p  saturating count of error events.
- ref_lost_o  output  1  window counter saturated in MEASURE without a reference edge.
- locked_o  output  1  high while in MEASURE.

Behaviour:
- Reset (tag_reset=0, async): all outputs, counters, sync flops and state = 0; state=IDLE.
- Sync: ref_toggle_i passes through sync_stages_p flops plus one history flop. edge = last_sync ^ history. An edge is detected sync_stages_p+1 clk_lo cycles after the toggle (±1).
- cnt_r increments every cycle and saturates at all-ones.
  - On an edge cycle: window = cnt_r+1, saturating; cnt_r <= 0.
  - A window equals the clk_lo cycles between consecutive edge cycles.
- FSM:
  - IDLE: cnt_r, settle counter, min/max, count_o, error state, ref_lost_o held at 0. en_i=1 -> ARM.
  - ARM: the partial window is discarded. The first edge goes to SETTLE, or to MEASURE if settle_windows_p=0.
  - SETTLE: each edge discards a window and increments the settle counter. After settle_windows_p discarded windows -> MEASURE.
  - MEASURE, on each edge:
    - count_o <= window; count_v_o=1 the following cycle only.
    - First measured window loads both min_o and max_o; later windows update them.
    - |window - expected_i| > tolerance_i (computed at count_width_p+1 bits, no wrap) -> error_o<=1, error_count_o++ (saturating).
    - Equality at the tolerance boundary is not an error.
  - en_i=0 from any state -> IDLE on the next cycle. Statistics, error_o, error_count_o and ref_lost_o are cleared.
- Ref loss: in MEASURE, cnt_r reaching all-ones sets ref_lost_o and error_o, and increments error_count_o once per loss event.
  - The next edge clears ref_lost_o. That window is reported as all-ones and also counts as an out-of-tolerance error if outside the band.
- Simultaneous edge and en_i fall: en_i wins; no count_v_o pulse.
- expected_i and tolerance_i are sampled combinationally at edge cycles; software holds them stable while locked.
- error_count_o holds at 2^err_count_width_p-1.
- Async reset mid-window: immediate return to IDLE.
  - After release with en_i=1: ARM, then settle_windows_p discarded windows, then measurement restarts.

Test Plan:
- Lock and measure:
  - Stimulus: clk_lo 10 ns, ref toggles every 200 ns, expected=20, tol=1, settle=1.
  - Response: locked_o rises after 2nd detected edge; count_o=20, count_v_o pulses every 20 cycles; min=max=20; error_o=0.
- Settle filter:
  - Stimulus: first window after arming shortened to 5 cycles.
  - Response: discarded; no error; min_o=20.
- Tolerance boundary:
  - Stimulus: windows of 21 then 22, expected=20, tol=1.
  - Response: 21 gives no error; 22 gives error_o=1, error_count_o=1, max_o=22.
- Ref loss:
  - Stimulus: count_width_p=8, stop ref toggles in MEASURE.
  - Response: after cnt_r reaches 255, ref_lost_o=1 and error_count_o increments once. Resuming toggles clears ref_lost_o; that window reports 255.
- Enable clear:
  - Stimulus: en_i=0 for 1 cycle with error_o=1.
  - Response: next cycle all outputs 0, state IDLE. Re-enable requires ARM plus settle again.
- Counter saturation and async reset:
  - Stimulus: err_count_width_p=2, force 5 bad windows.
  - Response: error_count_o stays 3.
  - Stimulus: pulse tag_reset low mid-window.
  - Response: outputs 0 immediately; locked_o low until re-settled.
